// File: rtl/fetch_queue.sv
// Instruction fetch stage: one-outstanding memory read handshake feeding a small PC-tagged FIFO toward decode.
// Define FETCH_HALT_ZERO_EN to stop fetching after an all-zero instruction word (exit via branch or reset).
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        halted
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, STOP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          zero_word;
    logic [31:0]   target;
    logic [31:0]   next_addr;

    assign target      = br_target & ~32'h3;
    assign next_addr   = mem_addr + 32'd4;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? word_q[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr] : '0;

    // A branch squashes both the word being acked and the pop at the same edge.
    assign push       = (state == REQ) && mem_ack && !br_taken;
    assign pop        = instr_valid && instr_ready && !br_taken;
    assign count_next = count + CW'(push) - CW'(pop);

`ifdef FETCH_HALT_ZERO_EN
    logic halt_q;

    assign zero_word = (mem_rdata == 32'h0);
    assign halted    = halt_q;

    always_ff @(posedge clk1) begin
        if (!rst_n)
            halt_q <= 1'b0;
        else if (push && zero_word)
            halt_q <= 1'b1;
        else if (state == STOP && br_taken)
            halt_q <= 1'b0;
    end
`else
    assign zero_word = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk1) begin
        if (rst_n && push) begin
            word_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= mem_addr;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (br_taken) begin
                        fetch_pc <= target;
                    end else if (count < FULL_CNT) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // The FIFO is emptied by a branch, so a redirect can reissue at once.
                    if (mem_ack && br_taken) begin
                        fetch_pc <= target;
                        mem_addr <= target;
                    end else if (mem_ack && zero_word) begin
                        fetch_pc <= next_addr;
                        mem_req  <= 1'b0;
                        state    <= STOP;
                    end else if (mem_ack) begin
                        fetch_pc <= next_addr;
                        if (count_next < FULL_CNT) begin
                            mem_addr <= next_addr;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (br_taken) begin
                        fetch_pc <= target;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (br_taken)
                        fetch_pc <= target;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                STOP: begin
                    if (br_taken) begin
                        fetch_pc <= target;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    assert property (@(posedge clk1) disable iff (!rst_n) !(push && count == FULL_CNT));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural memory answers requests at the falling edge,
// and hand-computed instr/instr_pc/mem_addr sequences are checked just after each rising edge.
module tb_fetch_queue;
    logic        clk1;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halted;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          wait_cnt     = 0;
    int          need_wait    = 0;
    int          slow_delay   = 3;
    logic [31:0] slow_addr    = 32'hFFFF_FFFF;
    logic [31:0] zero_addr    = 32'hFFFF_FFFF;
    logic [31:0] ack_log  [$];
    logic [31:0] pop_pc   [$];
    logic [31:0] pop_data [$];
    logic        found;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halted      (halted)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Memory returns addr+0x100 (or 0 at zero_addr); slow_addr waits slow_delay cycles before acking.
    always @(negedge clk1) begin
        if (!mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            need_wait = (mem_addr == slow_addr) ? slow_delay : 0;
            if (wait_cnt >= need_wait) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
        mem_rdata = (mem_addr == zero_addr) ? 32'h0 : mem_addr + 32'h100;
        if (rst_n && mem_req && mem_ack)
            ack_log.push_back(mem_addr);
        if (rst_n && instr_valid && instr_ready && !br_taken) begin
            pop_pc.push_back(instr_pc);
            pop_data.push_back(instr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic br, input logic [31:0] tgt);
        instr_ready = ready;
        br_taken    = br;
        br_target   = tgt;
        @(posedge clk1);
        #1;
    endtask

    // Returns just after the first edge that samples rst_n high.
    task automatic resetDut(input logic ready);
        rst_n = 1'b0;
        applyStimulus(ready, 1'b0, 32'h0);
        applyStimulus(ready, 1'b0, 32'h0);
        ack_log.delete();
        pop_pc.delete();
        pop_data.delete();
        rst_n = 1'b1;
        applyStimulus(ready, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;

        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);

        // Streaming with zero-latency ack and ready held high.
        resetDut(1'b1);
        checkOutput("lat_req", {31'b0, mem_req}, 32'h1);
        checkOutput("lat_addr", mem_addr, 32'h0);
        checkOutput("lat_valid", {31'b0, instr_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("stream_valid", {31'b0, instr_valid}, 32'h1);
            checkOutput("stream_instr", instr, 32'(32'h100 + 4 * k));
            checkOutput("stream_pc", instr_pc, 32'(4 * k));
        end
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        checkOutput("wrap_br_addr", mem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_br_valid", {31'b0, instr_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_next_addr", mem_addr, 32'h0);
        checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_instr", instr, 32'h0000_00FC);

        // Back-pressure: four acks fill the FIFO, then one pop frees one slot.
        resetDut(1'b0);
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("full_acks", 32'(ack_log.size()), 32'd4);
        checkOutput("full_req", {31'b0, mem_req}, 32'h0);
        checkOutput("full_head", instr, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("refill_acks", 32'(ack_log.size()), 32'd5);
        checkOutput("refill_addr", (ack_log.size() > 4) ? ack_log[4] : 32'hDEAD_BEEF, 32'h10);
        checkOutput("refill_req", {31'b0, mem_req}, 32'h0);
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("order_pc", (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));
            checkOutput("order_data", (pop_data.size() > i) ? pop_data[i] : 32'hDEAD_BEEF, 32'(32'h100 + 4 * i));
        end

        // Branch while the request at 0x8 is still waiting for its ack.
        slow_addr = 32'h8;
        resetDut(1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("slow_addr", mem_addr, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h203);
        checkOutput("disc_req", {31'b0, mem_req}, 32'h1);
        checkOutput("disc_addr", mem_addr, 32'h8);
        checkOutput("disc_valid", {31'b0, instr_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("disc_hold_addr", mem_addr, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("disc_done_req", {31'b0, mem_req}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_req", {31'b0, mem_req}, 32'h1);
        checkOutput("redir_addr", mem_addr, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_pc", instr_pc, 32'h200);
        checkOutput("redir_instr", instr, 32'h300);
        found = 1'b0;
        foreach (pop_data[i]) if (pop_data[i] == 32'h108) found = 1'b1;
        checkOutput("disc_dropped", {31'b0, found}, 32'h0);
        slow_addr = 32'hFFFF_FFFF;

        // Branch on the same edge as an ack and a pop, with two entries queued.
        resetDut(1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("two_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("two_addr", mem_addr, 32'h8);
        applyStimulus(1'b1, 1'b1, 32'h80);
        checkOutput("flush_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("flush_req", {31'b0, mem_req}, 32'h1);
        checkOutput("flush_addr", mem_addr, 32'h80);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("flush_pops", 32'(pop_pc.size()), 32'd0);
        checkOutput("flush_pc", instr_pc, 32'h80);
        checkOutput("flush_instr", instr, 32'h180);

        // Steady push+pop with two entries held in the FIFO.
        resetDut(1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("pp_pc", instr_pc, 32'(4 * k));
            checkOutput("pp_addr", mem_addr, 32'(8 + 4 * k));
        end
        instr_ready = 1'b0;
        checkOutput("pp_pops", 32'(pop_pc.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            checkOutput("pp_order", (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));

        // A zero word at 0xC: halts fetch only when the feature is built in.
        zero_addr = 32'hC;
        resetDut(1'b1);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("zero_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("zero_instr", instr, 32'h0);
        checkOutput("zero_pc", instr_pc, 32'hC);
`ifdef FETCH_HALT_ZERO_EN
        checkOutput("halt_set", {31'b0, halted}, 32'h1);
        checkOutput("halt_req", {31'b0, mem_req}, 32'h0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("halt_acks", 32'(ack_log.size()), 32'd4);
        checkOutput("halt_still_req", {31'b0, mem_req}, 32'h0);
        checkOutput("halt_deliv_pc", (pop_pc.size() > 3) ? pop_pc[3] : 32'hDEAD_BEEF, 32'hC);
        checkOutput("halt_deliv_data", (pop_data.size() > 3) ? pop_data[3] : 32'hDEAD_BEEF, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h40);
        checkOutput("halt_clear", {31'b0, halted}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("resume_req", {31'b0, mem_req}, 32'h1);
        checkOutput("resume_addr", mem_addr, 32'h40);
`else
        checkOutput("nohalt_flag", {31'b0, halted}, 32'h0);
        checkOutput("nohalt_req", {31'b0, mem_req}, 32'h1);
        checkOutput("nohalt_addr", mem_addr, 32'h10);
`endif
        zero_addr = 32'hFFFF_FFFF;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
